branch_resolve_sched: RTL and testbench

In-order scheduler that sequences conditional branches through the integer branch-evaluation datapath. It buffers up to `DEPTH` issued branches and resolves one per cycle from the head. Each result is checked against the front-end prediction, and on a mispredict the block raises a redirect, squashes younger queued branches and holds issue for a recovery window. It sits between the issue stage and the branch unit, and drives the fetch redirect path.

---
 rtl/branch_pkg.sv | 33 +++
 rtl/branch_eval.sv | 50 +++++
 rtl/branch_resolve_sched.sv | 184 ++++++++++++++++++
 tb/tb_branch_resolve_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the in-order branch resolve scheduler.
package branch_pkg;

  localparam int unsigned BR_XLEN = 64;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] offset;
    logic [2:0]         funct3;
    logic [BR_XLEN-1:0] src1;
    logic [BR_XLEN-1:0] src2;
    logic               pred_taken;
    logic [BR_XLEN-1:0] pred_target;
  } branch_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } brsched_state_t;

  // Only 010 and 011 are undefined in the branch funct3 space.
  function automatic logic f3_is_valid(input logic [2:0] f3);
    return f3[2] | ~f3[1];
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Combinational branch evaluation for the queue head: direction, next PC,
// illegal-encoding flag and mispredict detection against the prediction.
module branch_eval
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            taken_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            invalid_o,
  output logic            mispredict_o
);

  logic            taken_s;
  logic            invalid_s;
  logic [XLEN-1:0] target_s;

  // Direction compare per funct3; illegal encodings resolve not-taken.
  always_comb begin
    taken_s = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_s = (src1_i == src2_i);
      F3_BNE:  taken_s = (src1_i != src2_i);
      F3_BLT:  taken_s = ($signed(src1_i) <  $signed(src2_i));
      F3_BGE:  taken_s = ($signed(src1_i) >= $signed(src2_i));
      F3_BLTU: taken_s = (src1_i <  src2_i);
      F3_BGEU: taken_s = (src1_i >= src2_i);
      default: taken_s = 1'b0;
    endcase
  end

  assign invalid_s = ~f3_is_valid(funct3_i);
  assign target_s  = pc_i + offset_i;

  assign taken_o      = taken_s;
  assign invalid_o    = invalid_s;
  assign next_pc_o    = taken_s ? target_s : (pc_i + XLEN'(4));
  // An illegal branch is reported via invalid_o, never as a redirect.
  assign mispredict_o = ~invalid_s &
                        ((taken_s != pred_taken_i) |
                         (taken_s & (target_s != pred_target_i)));

endmodule

// File: rtl/branch_resolve_sched.sv
// In-order branch scheduler: FIFO of issued branches, one resolve per cycle
// from the head, squash and recovery window on mispredict or illegal branch.
module branch_resolve_sched
  import branch_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [XLEN-1:0]            enq_pc_i,
  input  logic [XLEN-1:0]            enq_offset_i,
  input  logic [2:0]                 enq_funct3_i,
  input  logic [XLEN-1:0]            enq_src1_i,
  input  logic [XLEN-1:0]            enq_src2_i,
  input  logic                       enq_pred_taken_i,
  input  logic [XLEN-1:0]            enq_pred_target_i,
  output logic                       res_valid_o,
  output logic                       res_taken_o,
  output logic [XLEN-1:0]            res_next_pc_o,
  output logic                       redirect_o,
  output logic [XLEN-1:0]            redirect_pc_o,
  output logic                       invalid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [RW-1:0] RECOVER_C = RW'(RECOVER_CYCLES);

  branch_entry_t  mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  brsched_state_t state_q, state_d;
  logic [RW-1:0]  rec_q, rec_d;

  logic            res_valid_q, res_valid_d;
  logic            res_taken_q, res_taken_d;
  logic [XLEN-1:0] res_next_pc_q, res_next_pc_d;
  logic            redirect_q, redirect_d;
  logic            invalid_q, invalid_d;

  branch_entry_t   head_s, enq_entry_s;
  logic            ready_s, push_s, pop_s, squash_s;
  logic            ev_taken_s, ev_invalid_s, ev_mispredict_s;
  logic [XLEN-1:0] ev_next_pc_s;

  assign head_s = mem_q[head_q];

  assign enq_entry_s.pc          = BR_XLEN'(enq_pc_i);
  assign enq_entry_s.offset      = BR_XLEN'(enq_offset_i);
  assign enq_entry_s.funct3      = enq_funct3_i;
  assign enq_entry_s.src1        = BR_XLEN'(enq_src1_i);
  assign enq_entry_s.src2        = BR_XLEN'(enq_src2_i);
  assign enq_entry_s.pred_taken  = enq_pred_taken_i;
  assign enq_entry_s.pred_target = BR_XLEN'(enq_pred_target_i);

  branch_eval #(.XLEN(XLEN)) u_eval (
    .pc_i          (XLEN'(head_s.pc)),
    .offset_i      (XLEN'(head_s.offset)),
    .funct3_i      (head_s.funct3),
    .src1_i        (XLEN'(head_s.src1)),
    .src2_i        (XLEN'(head_s.src2)),
    .pred_taken_i  (head_s.pred_taken),
    .pred_target_i (XLEN'(head_s.pred_target)),
    .taken_o       (ev_taken_s),
    .next_pc_o     (ev_next_pc_s),
    .invalid_o     (ev_invalid_s),
    .mispredict_o  (ev_mispredict_s)
  );

  // No bypass: a full queue stays not-ready even in a popping cycle.
  assign ready_s  = (state_q == RUN) && (count_q < DEPTH_C) && !flush_i;
  assign push_s   = enq_valid_i && ready_s;
  assign pop_s    = (state_q == RUN) && (count_q != '0);
  assign squash_s = pop_s && (ev_mispredict_s || ev_invalid_s);

  // Next-state for queue pointers, occupancy and recovery FSM.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    rec_d   = rec_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = RUN;
      rec_d   = '0;
    end else if (squash_s) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = RECOVER;
      rec_d   = RECOVER_C;
    end else if (state_q == RECOVER) begin
      if (rec_q <= RW'(1)) begin
        state_d = RUN;
        rec_d   = '0;
      end else begin
        rec_d = rec_q - RW'(1);
      end
    end else begin
      head_d  = head_q + PW'(pop_s);
      tail_d  = tail_q + PW'(push_s);
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Result registers: only a non-flushed pop produces a visible result.
  always_comb begin
    res_valid_d   = 1'b0;
    res_taken_d   = 1'b0;
    res_next_pc_d = '0;
    redirect_d    = 1'b0;
    invalid_d     = 1'b0;
    if (pop_s && !flush_i) begin
      res_valid_d   = 1'b1;
      res_taken_d   = ev_taken_s;
      res_next_pc_d = ev_next_pc_s;
      redirect_d    = ev_mispredict_s;
      invalid_d     = ev_invalid_s;
    end else begin
      res_valid_d = 1'b0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= RUN;
      rec_q         <= '0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      res_next_pc_q <= '0;
      redirect_q    <= 1'b0;
      invalid_q     <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      state_q       <= state_d;
      rec_q         <= rec_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      res_next_pc_q <= res_next_pc_d;
      redirect_q    <= redirect_d;
      invalid_q     <= invalid_d;
    end
  end

  // Entry storage; a squashed or flushed write is harmless since pointers reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[tail_q] <= enq_entry_s;
    end else begin
      mem_q[tail_q] <= mem_q[tail_q];
    end
  end

  assign enq_ready_o   = ready_s;
  assign res_valid_o   = res_valid_q;
  assign res_taken_o   = res_taken_q;
  assign res_next_pc_o = res_next_pc_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = res_next_pc_q;
  assign invalid_o     = invalid_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_branch_resolve_sched.sv
// Scoreboard bench: a queue-level reference model predicts each resolve,
// a negedge monitor pops and compares whenever the DUT presents a result.
module tb_branch_resolve_sched;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int RC    = 2;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            flush_i;
  logic            enq_valid_i;
  logic            enq_ready_o;
  logic [63:0]     enq_pc_i, enq_offset_i, enq_src1_i, enq_src2_i, enq_pred_target_i;
  logic [2:0]      enq_funct3_i;
  logic            enq_pred_taken_i;
  logic            res_valid_o, res_taken_o, redirect_o, invalid_o;
  logic [63:0]     res_next_pc_o, redirect_pc_o;
  logic [2:0]      count_o;

  always #5 clk_i = ~clk_i;

  branch_resolve_sched #(.XLEN(XLEN), .DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_pc_i(enq_pc_i), .enq_offset_i(enq_offset_i), .enq_funct3_i(enq_funct3_i),
    .enq_src1_i(enq_src1_i), .enq_src2_i(enq_src2_i),
    .enq_pred_taken_i(enq_pred_taken_i), .enq_pred_target_i(enq_pred_target_i),
    .res_valid_o(res_valid_o), .res_taken_o(res_taken_o), .res_next_pc_o(res_next_pc_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .invalid_o(invalid_o),
    .count_o(count_o)
  );

  typedef struct {
    logic [63:0] pc, off;
    logic [2:0]  f3;
    logic [63:0] s1, s2;
    logic        pt;
    logic [63:0] ptgt;
  } br_t;

  typedef struct {
    time         t;
    logic        tk;
    logic [63:0] npc;
    logic        rd;
    logic        inv;
  } exp_t;

  br_t  mq[$];
  exp_t sb[$];
  int   rec;
  int   vectors;
  int   miscompares;
  bit   mon_en;
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic br_t mk(input logic [63:0] pc, input logic [63:0] off, input logic [2:0] f3,
                             input logic [63:0] s1, input logic [63:0] s2,
                             input logic pt, input logic [63:0] ptgt);
    br_t b;
    b.pc = pc; b.off = off; b.f3 = f3; b.s1 = s1; b.s2 = s2; b.pt = pt; b.ptgt = ptgt;
    return b;
  endfunction

  // Architectural branch semantics straight from the rules.
  function automatic void ref_resolve(input br_t b, output exp_t e, output logic squash);
    logic        tk;
    logic        inv;
    logic [63:0] tgt;
    inv = 1'b0;
    tgt = b.pc + b.off;
    case (b.f3)
      3'd0:    tk = (b.s1 == b.s2);
      3'd1:    tk = (b.s1 != b.s2);
      3'd4:    tk = ($signed(b.s1) <  $signed(b.s2));
      3'd5:    tk = ($signed(b.s1) >= $signed(b.s2));
      3'd6:    tk = (b.s1 <  b.s2);
      3'd7:    tk = (b.s1 >= b.s2);
      default: begin tk = 1'b0; inv = 1'b1; end
    endcase
    e.t   = 0;
    e.tk  = tk;
    e.npc = tk ? tgt : b.pc + 64'd4;
    e.inv = inv;
    e.rd  = !inv && ((tk != b.pt) || (tk && tgt != b.ptgt));
    squash = e.rd || inv;
  endfunction

  task automatic step(input br_t b, input logic v, input logic fl);
    time  t0;
    logic rdy;
    logic sq;
    exp_t e;
    br_t  h;
    @(negedge clk_i);
    t0 = $time;
    enq_valid_i = v;       flush_i = fl;
    enq_pc_i = b.pc;       enq_offset_i = b.off;   enq_funct3_i = b.f3;
    enq_src1_i = b.s1;     enq_src2_i = b.s2;
    enq_pred_taken_i = b.pt; enq_pred_target_i = b.ptgt;
    #1;
    rdy = (rec == 0) && (mq.size() < DEPTH) && !fl;
    chk("enq_ready", {63'd0, enq_ready_o}, {63'd0, rdy});
    chk("count", {61'd0, count_o}, 64'(mq.size()));
    sq = 1'b0;
    if (fl) begin
      mq.delete();
      rec = 0;
    end else if (rec > 0) begin
      rec--;
    end else begin
      if (mq.size() > 0) begin
        h = mq.pop_front();
        ref_resolve(h, e, sq);
        e.t = t0 + 10;
        sb.push_back(e);
        if (sq) begin
          mq.delete();
          rec = RC;
        end
      end
      if (!sq && v && rdy) mq.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    br_t z;
    z = mk(64'd0, 64'd0, 3'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    for (int i = 0; i < n; i++) step(z, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    #2;
    rstn_i = 1'b0; enq_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("rst_res_valid", {63'd0, res_valid_o}, 64'd0);
    chk("rst_redirect", {63'd0, redirect_o}, 64'd0);
    chk("rst_invalid", {63'd0, invalid_o}, 64'd0);
    chk("rst_next_pc", res_next_pc_o, 64'd0);
    chk("rst_count", {61'd0, count_o}, 64'd0);
    mq.delete(); sb.delete(); rec = 0;
    @(negedge clk_i);
    #2 rstn_i = 1'b1;
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'd5;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk_i) begin
    if (mon_en && rstn_i) begin
      if (res_valid_o) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got res_valid_o=1 expected no result at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("res_time", 64'($time), 64'(mon_e.t));
          chk("res_taken", {63'd0, res_taken_o}, {63'd0, mon_e.tk});
          chk("res_next_pc", res_next_pc_o, mon_e.npc);
          chk("redirect_pc", redirect_pc_o, mon_e.npc);
          chk("redirect", {63'd0, redirect_o}, {63'd0, mon_e.rd});
          chk("invalid", {63'd0, invalid_o}, {63'd0, mon_e.inv});
        end
      end else begin
        chk("pulse_without_valid", {62'd0, redirect_o, invalid_o}, 64'd0);
        if (sb.size() > 0 && sb[0].t <= $time) begin
          vectors++;
          miscompares++;
          $display("FAIL missing_result: got res_valid_o=0 expected result due at %0t", sb[0].t);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    br_t b;
    logic [63:0] pc, off, s1, s2;
    vectors = 0; miscompares = 0; rec = 0; mon_en = 1'b0;
    rstn_i = 1'b0; flush_i = 1'b0; enq_valid_i = 1'b0;
    enq_pc_i = '0; enq_offset_i = '0; enq_funct3_i = '0; enq_src1_i = '0; enq_src2_i = '0;
    enq_pred_taken_i = 1'b0; enq_pred_target_i = '0;
    #1;
    chk("reset_res_valid", {63'd0, res_valid_o}, 64'd0);
    chk("reset_count", {61'd0, count_o}, 64'd0);
    #21 rstn_i = 1'b1;
    mon_en = 1'b1;

    // Correctly predicted taken BEQ: result two cycles after acceptance.
    step(mk(64'h1000, 64'h40, 3'b000, 64'd5, 64'd5, 1'b1, 64'h1040), 1'b1, 1'b0);
    idle(2);
    chk("beq_taken", {63'd0, res_taken_o}, 64'd1);
    chk("beq_next_pc", res_next_pc_o, 64'h1040);
    chk("beq_redirect", {63'd0, redirect_o}, 64'd0);
    idle(2);

    // BLT signed mispredict followed by younger branches that get dropped.
    step(mk(64'h2000, 64'h10, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0), 1'b1, 1'b0);
    step(mk(64'h2004, 64'h8, 3'b000, 64'd1, 64'd1, 1'b1, 64'h200C), 1'b1, 1'b0);
    step(mk(64'h2008, 64'h8, 3'b000, 64'd1, 64'd1, 1'b1, 64'h2010), 1'b1, 1'b0);
    chk("blt_redirect", {63'd0, redirect_o}, 64'd1);
    chk("blt_redirect_pc", redirect_pc_o, 64'h2010);
    step(mk(64'h200C, 64'h8, 3'b000, 64'd1, 64'd1, 1'b1, 64'h2014), 1'b1, 1'b0);
    idle(4);

    // Unsigned compares with an all-ones operand.
    step(mk(64'h3000, 64'h20, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h3020), 1'b1, 1'b0);
    idle(5);
    step(mk(64'h3100, 64'h20, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h3120), 1'b1, 1'b0);
    idle(3);

    // Back-to-back correct predictions, twice, to exercise pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        pc = 64'h4000 + 64'(r * 64 + k * 8);
        step(mk(pc, 64'h100, 3'b001, 64'd3, 64'd7, 1'b1, pc + 64'h100), 1'b1, 1'b0);
      end
      idle(3);
    end

    // Illegal funct3 at the head.
    step(mk(64'h5000, 64'h40, 3'b010, 64'd1, 64'd1, 1'b1, 64'h5040), 1'b1, 1'b0);
    step(mk(64'h5004, 64'h40, 3'b000, 64'd1, 64'd1, 1'b1, 64'h5044), 1'b1, 1'b0);
    idle(4);

    // Flush coincident with a mispredicting pop.
    step(mk(64'h6000, 64'h40, 3'b000, 64'd1, 64'd2, 1'b1, 64'h6040), 1'b1, 1'b0);
    step(mk(64'h6004, 64'h40, 3'b000, 64'd1, 64'd1, 1'b1, 64'h6044), 1'b1, 1'b1);
    idle(1);
    chk("flush_no_redirect", {63'd0, redirect_o}, 64'd0);
    idle(2);

    // Reset pulsed while in the recovery window.
    step(mk(64'h7000, 64'h40, 3'b001, 64'd1, 64'd1, 1'b1, 64'h7040), 1'b1, 1'b0);
    idle(2);
    reset_pulse();
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      pc  = {$urandom(), $urandom()} & ~64'd3;
      off = ($urandom_range(0, 9) == 0) ? ~pc + 64'd1 : 64'({{20{1'b0}}, $urandom_range(0, 4095)} << 1);
      s1  = rnd_opnd();
      s2  = ($urandom_range(0, 3) == 0) ? s1 : rnd_opnd();
      b = mk(pc, off, 3'($urandom_range(0, 7)), s1, s2, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? pc + off : {$urandom(), $urandom()});
      step(b, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end
    idle(6);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
